lu_sweep_ctrl: RTL

Upstream stimulus and capture stage for the selectable AND/OR logic unit, whose inputs are a, b and chave and whose output is s.
- On a start request it drives all 8 {chave,a,b} combinations into the unit, one vector at a time.
- It waits a programmable settle time per vector, samples s, and builds an 8-bit truth table.
- It compares the table against the expected function: s = a|b when chave=0, s = a&b when chave=1.
- It reports pass/fail with a done pulse. Used for self-test of the unit in lab benches and on the board.

---
 rtl/lu_sweep_ctrl_pkg.sv | 18 +
 rtl/lu_settle_timer.sv | 25 ++
 rtl/lu_sweep_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/lu_sweep_ctrl_pkg.sv
// Shared definitions for the AND/OR logic-unit sweep controller: state
// encoding, the golden truth table and the operand bit positions in a vector.
package lu_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] EXPECTED_DEFAULT = 8'h8E;

  // Vector index is {chave,a,b}
  localparam int VEC_CHAVE = 2;
  localparam int VEC_A     = 1;
  localparam int VEC_B     = 0;

endpackage

// File: rtl/lu_settle_timer.sv
// 4-bit settle down-counter: loads a reload value, counts down to zero and
// parks there, flagging zero so the controller knows s may be sampled.
module lu_settle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] reload,
  output logic       zero
);

  logic [3:0] wcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= 4'd0;
    end else if (load) begin
      wcnt <= reload;
    end else if (wcnt != 4'd0) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  assign zero = (wcnt == 4'd0);

endmodule

// File: rtl/lu_sweep_ctrl.sv
// Self-test sweep controller: drives all eight {chave,a,b} vectors into the
// logic unit, captures s after a settle time and grades the truth table.
// Handshake: start is a level request, accepted only in IDLE; done is a
// one-cycle pulse after the last capture; busy covers the whole sweep.
module lu_sweep_ctrl
  import lu_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE   = 1,
  parameter logic [7:0]  EXPECTED = EXPECTED_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       s,
  output logic       a,
  output logic       b,
  output logic       chave,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic [7:0] mismatch,
  output logic       pass,
  output logic [1:0] state_dbg
);

  localparam logic [3:0] RELOAD = 4'(SETTLE);

  state_t     state, state_d;
  logic [2:0] idx;
  logic [7:0] table_cap;
  logic       accept, capture, last, load, zero;

  lu_settle_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .reload (RELOAD),
    .zero   (zero)
  );

  assign last = (idx == 3'd7);
  assign load = accept | (capture & ~last);

  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    capture   = 1'b0;
    table_cap = table_out;
    table_cap[idx] = s;
    case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (zero) begin
          capture = 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      table_out <= 8'h00;
      mismatch  <= 8'h00;
      pass      <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        idx       <= 3'd0;
        table_out <= 8'h00;
        mismatch  <= 8'h00;
        pass      <= 1'b0;
      end else if (capture) begin
        table_out <= table_cap;
        // Grade on the final capture so pass/mismatch appear with done
        if (last) begin
          mismatch <= table_cap ^ EXPECTED;
          pass     <= (table_cap == EXPECTED);
        end else begin
          idx <= idx + 3'd1;
        end
      end
    end
  end

  always_comb begin
    chave = 1'b0;
    a     = 1'b0;
    b     = 1'b0;
    if (state == WAIT) begin
      chave = idx[VEC_CHAVE];
      a     = idx[VEC_A];
      b     = idx[VEC_B];
    end
  end

  assign busy      = (state == WAIT);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule
